// File: rtl/port_link.sv
// Half-duplex byte link over a strobe pin (io1) and a 2-bit data bus (io2); one module for both ends.
// Latency: accept -> rx_valid 4 cycles, tx_done 6 cycles (5 / 7 with PORT_LINK_PARITY_EN defined).
// Backpressure: initiator tx_ready is high only in IDLE; the responder never stalls, rx_valid is a pulse.
//
// Ports: clk, rst_n (async active-low); tx_valid/tx_data/tx_ready/tx_done/tx_status (initiator side);
// rx_valid/rx_data (responder side); io1 strobe and io2 beat/status, both released to z when not driven.
// Optional feature macro: PORT_LINK_PARITY_EN adds a 5th even-parity beat and a parity-error status.
module port_link #(
    parameter int INITIATOR   = 1,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic [1:0] tx_status,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    inout  wire        io1,
    inout  wire  [1:0] io2
);

`ifdef PORT_LINK_PARITY_EN
    localparam logic [2:0] LAST_BEAT = 3'd4;
    localparam int         SHW       = 8;
`else
    localparam logic [2:0] LAST_BEAT = 3'd3;
    localparam int         SHW       = 6;
`endif

    logic       drv_en;
    logic [1:0] drv_io2;
    logic       strobe;

    // Only a driven 1 counts as a strobe; z/x/0 all read as idle.
    assign strobe = (io1 == 1'b1);
    assign io1    = drv_en ? 1'b1    : 1'bz;
    assign io2    = drv_en ? drv_io2 : 2'bzz;

    if (INITIATOR != 0) begin : g_ini
        typedef enum logic [1:0] {I_IDLE, I_BEAT, I_TURN, I_WAIT} ini_state_t;
        localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

        ini_state_t state, state_nxt;
        logic [7:0] data_q;
        logic [2:0] beat_cnt;
        logic [7:0] wait_cnt;
        logic       done_q;
        logic [1:0] status_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state <= I_IDLE;
            else        state <= state_nxt;
        end

        always_comb begin
            state_nxt = state;
            drv_en    = 1'b0;
            drv_io2   = 2'b00;
            case (state)
                I_IDLE: if (tx_valid) state_nxt = I_BEAT;
                I_BEAT: begin
                    drv_en = 1'b1;
                    case (beat_cnt)
                        3'd0:    drv_io2 = data_q[7:6];
                        3'd1:    drv_io2 = data_q[5:4];
                        3'd2:    drv_io2 = data_q[3:2];
                        3'd3:    drv_io2 = data_q[1:0];
                        default: drv_io2 = {1'b0, ^data_q};   // parity beat
                    endcase
                    if (beat_cnt == LAST_BEAT) state_nxt = I_TURN;
                end
                I_TURN: state_nxt = I_WAIT;
                I_WAIT: if (strobe || wait_cnt == WAIT_LAST) state_nxt = I_IDLE;
                default: state_nxt = I_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q   <= '0;
                beat_cnt <= '0;
                wait_cnt <= '0;
                done_q   <= 1'b0;
                status_q <= 2'b00;
            end else begin
                done_q <= 1'b0;
                case (state)
                    I_IDLE: if (tx_valid) begin
                        data_q   <= tx_data;
                        beat_cnt <= '0;
                    end
                    I_BEAT: beat_cnt <= beat_cnt + 3'd1;
                    I_TURN: wait_cnt <= '0;
                    I_WAIT: begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (strobe) begin
                            done_q   <= 1'b1;
                            status_q <= io2;
                        end else if (wait_cnt == WAIT_LAST) begin
                            done_q   <= 1'b1;
                            status_q <= 2'b00;            // timeout
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign tx_ready  = (state == I_IDLE);
        assign tx_done   = done_q;
        assign tx_status = status_q;
        assign rx_valid  = 1'b0;
        assign rx_data   = 8'h00;
    end else begin : g_rsp
        typedef enum logic [1:0] {R_IDLE, R_CAPT, R_TURN, R_ACK} rsp_state_t;

        rsp_state_t     state, state_nxt;
        logic [SHW-1:0] sh;
        logic [2:0]     cnt;
        logic [7:0]     rx_data_q;
        logic           rx_valid_q;
        logic [1:0]     st_q;
        logic           unused_tx;

        assign unused_tx = ^{tx_valid, tx_data};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state <= R_IDLE;
            else        state <= state_nxt;
        end

        always_comb begin
            state_nxt = state;
            drv_en    = 1'b0;
            drv_io2   = st_q;
            case (state)
                R_IDLE: if (strobe) state_nxt = R_CAPT;
                // A gap in the strobe mid-byte drops the partial byte silently.
                R_CAPT: begin
                    if (!strobe)                 state_nxt = R_IDLE;
                    else if (cnt == LAST_BEAT)   state_nxt = R_TURN;
                end
                R_TURN: state_nxt = R_ACK;
                R_ACK: begin
                    drv_en    = 1'b1;
                    state_nxt = R_IDLE;
                end
                default: state_nxt = R_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sh         <= '0;
                cnt        <= '0;
                rx_data_q  <= '0;
                rx_valid_q <= 1'b0;
                st_q       <= 2'b00;
            end else begin
                rx_valid_q <= 1'b0;
                case (state)
                    R_IDLE: if (strobe) begin
                        sh  <= {sh[SHW-3:0], io2};
                        cnt <= 3'd1;
                    end
                    R_CAPT: if (strobe) begin
                        cnt <= cnt + 3'd1;
                        if (cnt < 3'd4) sh <= {sh[SHW-3:0], io2};
                        if (cnt == LAST_BEAT) begin
                            rx_valid_q <= 1'b1;
`ifdef PORT_LINK_PARITY_EN
                            // Data is already complete in sh; io2 holds the parity beat.
                            rx_data_q <= sh;
                            st_q      <= (io2 == {1'b0, ^sh}) ? 2'b01 : 2'b10;
`else
                            rx_data_q <= {sh, io2};
                            st_q      <= 2'b01;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign tx_ready  = 1'b0;
        assign tx_done   = 1'b0;
        assign tx_status = 2'b00;
        assign rx_valid  = rx_valid_q;
        assign rx_data   = rx_data_q;
    end

endmodule

// File: tb/tb_port_link.sv
// Bench for port_link: initiator/responder pair on shared pins plus a bench pin driver.
// Latency: checks exact cycle positions of beats, rx_valid, ack and tx_done.
// Backpressure: exercises held tx_valid, timeout with a silent responder and async reset mid-byte.
module tb_port_link;

`ifdef PORT_LINK_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int TO = 8;

    typedef struct {
        logic [7:0] data;
        logic [7:0] beats;    // beat0..beat3, MSB pair first
        logic [1:0] par;      // expected 5th beat
        logic [1:0] status;   // expected ack status
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_ini_n, rst_rsp_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       rsp_tx_valid;
    logic [7:0] rsp_tx_data;
    logic       ini_tx_ready, ini_tx_done, ini_rx_valid;
    logic [1:0] ini_tx_status;
    logic [7:0] ini_rx_data;
    logic       rsp_tx_ready, rsp_tx_done, rsp_rx_valid;
    logic [1:0] rsp_tx_status;
    logic [7:0] rsp_rx_data;
    logic       tb_drv;
    logic [1:0] tb_io2;
    wire        io1;
    wire  [1:0] io2;

    assign io1 = tb_drv ? 1'b1   : 1'bz;
    assign io2 = tb_drv ? tb_io2 : 2'bzz;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] rx_q[$];
    logic [1:0] st_q[$];
    vec_t vt[6];

    always #5 clk = ~clk;

    port_link #(.INITIATOR(1), .ACK_TIMEOUT(TO)) u_ini (
        .clk(clk), .rst_n(rst_ini_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(ini_tx_ready), .tx_done(ini_tx_done), .tx_status(ini_tx_status),
        .rx_valid(ini_rx_valid), .rx_data(ini_rx_data), .io1(io1), .io2(io2));

    port_link #(.INITIATOR(0), .ACK_TIMEOUT(TO)) u_rsp (
        .clk(clk), .rst_n(rst_rsp_n), .tx_valid(rsp_tx_valid), .tx_data(rsp_tx_data),
        .tx_ready(rsp_tx_ready), .tx_done(rsp_tx_done), .tx_status(rsp_tx_status),
        .rx_valid(rsp_rx_valid), .rx_data(rsp_rx_data), .io1(io1), .io2(io2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit pin_hi();
        return (io1 === 1'b1);
    endfunction

    // Scoreboard: received bytes and completion status popped as the DUTs produce them.
    always @(negedge clk) begin
        if (rst_rsp_n === 1'b1 && rsp_rx_valid === 1'b1) begin
            chk("rx_expected", rx_q.size() != 0, 1);
            if (rx_q.size() != 0) chk("rx_data", rsp_rx_data, rx_q.pop_front());
        end
        if (rst_ini_n === 1'b1 && ini_tx_done === 1'b1) begin
            chk("done_expected", st_q.size() != 0, 1);
            if (st_q.size() != 0) chk("tx_status", ini_tx_status, st_q.pop_front());
        end
    end

    // Call at a negedge with the initiator idle; returns at the negedge of the tx_done cycle.
    task automatic xfer(input vec_t v, input bit keep, input bit live);
        logic [7:0] bts;
        logic [1:0] exp;
        bts = v.beats;
        chk("ready_before", ini_tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = v.data;
        if (live) rx_q.push_back(v.data);
        st_q.push_back(live ? v.status : 2'b00);
        @(posedge clk);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            if (k == 0 && !keep) tx_valid = 1'b0;
            exp = (k < 4) ? bts[7-2*k -: 2] : v.par;
            chk("beat_strobe", pin_hi(), 1);
            chk("beat_data", io2, exp);
            if (k == 0) chk("ready_busy", ini_tx_ready, 0);
        end
        if (live) begin
            @(negedge clk);
            chk("turn_released", pin_hi(), 0);
            chk("rx_valid_turn", rsp_rx_valid, 1);
            chk("done_early", ini_tx_done, 0);
            @(negedge clk);
            chk("ack_strobe", pin_hi(), 1);
            chk("ack_status", io2, v.status);
            chk("rx_valid_pulse", rsp_rx_valid, 0);
            @(negedge clk);
            chk("done_cycle", ini_tx_done, 1);
            chk("ready_after", ini_tx_ready, 1);
            chk("done_released", pin_hi(), 0);
        end else begin
            repeat (TO + 1) @(negedge clk);
            chk("timeout_early", ini_tx_done, 0);
            @(negedge clk);
            chk("timeout_done", ini_tx_done, 1);
            chk("timeout_status", ini_tx_status, 2'b00);
            chk("timeout_ready", ini_tx_ready, 1);
        end
    endtask

    initial begin
        vec_t v;
        vt[0] = '{8'hA5, {2'b10, 2'b10, 2'b01, 2'b01}, 2'b00, 2'b01};
        vt[1] = '{8'h5A, {2'b01, 2'b01, 2'b10, 2'b10}, 2'b00, 2'b01};
        vt[2] = '{8'h3C, {2'b00, 2'b11, 2'b11, 2'b00}, 2'b00, 2'b01};
        vt[3] = '{8'h81, {2'b10, 2'b00, 2'b00, 2'b01}, 2'b00, 2'b01};
        vt[4] = '{8'h07, {2'b00, 2'b00, 2'b01, 2'b11}, 2'b01, 2'b01};
        vt[5] = '{8'hC3, {2'b11, 2'b00, 2'b00, 2'b11}, 2'b00, 2'b01};

        rst_ini_n    = 1'b0;
        rst_rsp_n    = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        rsp_tx_valid = 1'b0;
        rsp_tx_data  = 8'h00;
        tb_drv       = 1'b0;
        tb_io2       = 2'b00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ini_ready", ini_tx_ready, 1);
        chk("rst_ini_done", ini_tx_done, 0);
        chk("rst_ini_status", ini_tx_status, 0);
        chk("rst_rsp_ready", rsp_tx_ready, 0);
        chk("rst_rsp_rx_valid", rsp_rx_valid, 0);
        chk("rst_rsp_rx_data", rsp_rx_data, 0);
        chk("rst_ini_rx_valid", ini_rx_valid, 0);
        chk("rst_pin", pin_hi(), 0);
        rst_ini_n = 1'b1;
        rst_rsp_n = 1'b1;
        @(negedge clk);

        // Table-driven transfers
        for (int i = 0; i < 6; i++) xfer(vt[i], 1'b0, 1'b1);

        // Back-to-back with tx_valid held: second accept at end of the done cycle
        v = '{8'h00, 8'h00, 2'b00, 2'b01};
        xfer(v, 1'b1, 1'b1);
        v = '{8'hFF, 8'hFF, 2'b00, 2'b01};
        xfer(v, 1'b0, 1'b1);
        @(negedge clk);

        // Timeout with a silent responder
        rst_rsp_n = 1'b0;
        xfer(vt[2], 1'b0, 1'b0);
        @(negedge clk);
        rst_rsp_n = 1'b1;
        @(negedge clk);

        // Async reset of the initiator during beat 2
        tx_valid = 1'b1;
        tx_data  = 8'h96;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_beat2", pin_hi(), 1);
        #2 rst_ini_n = 1'b0;
        #1;
        chk("rst_mid_pin", pin_hi(), 0);
        chk("rst_mid_ready", ini_tx_ready, 1);
        chk("rst_mid_done", ini_tx_done, 0);
        @(negedge clk);
        rst_ini_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_no_rx", rsp_rx_valid, 0);
            chk("rst_mid_no_ack", pin_hi(), 0);
        end
        xfer(vt[1], 1'b0, 1'b1);

        // Bench drives only two beats into the responder
        tb_drv = 1'b1;
        tb_io2 = 2'b10;
        @(negedge clk);
        tb_io2 = 2'b01;
        @(negedge clk);
        tb_drv = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("short_no_rx", rsp_rx_valid, 0);
            chk("short_no_ack", pin_hi(), 0);
        end
        xfer(vt[3], 1'b0, 1'b1);

`ifdef PORT_LINK_PARITY_EN
        // Bench-driven 8'h07 with a wrong parity beat
        @(negedge clk);
        rx_q.push_back(8'h07);
        tb_drv = 1'b1;
        tb_io2 = 2'b00;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            case (k)
                1:       tb_io2 = 2'b00;
                2:       tb_io2 = 2'b01;
                3:       tb_io2 = 2'b11;
                default: tb_io2 = 2'b00;   // correct parity would be 2'b01
            endcase
        end
        @(negedge clk);
        tb_drv = 1'b0;
        chk("bad_par_rx_valid", rsp_rx_valid, 1);
        chk("bad_par_rx_data", rsp_rx_data, 8'h07);
        @(negedge clk);
        chk("bad_par_ack", pin_hi(), 1);
        chk("bad_par_status", io2, 2'b10);
        @(negedge clk);
        chk("bad_par_release", pin_hi(), 0);
`endif

        repeat (3) @(negedge clk);
        chk("rx_q_drained", rx_q.size(), 0);
        chk("st_q_drained", st_q.size(), 0);
        chk("rsp_tx_done_tied", rsp_tx_done, 0);
        chk("rsp_tx_status_tied", rsp_tx_status, 0);
        chk("ini_rx_data_tied", ini_rx_data, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
